// File: rtl/tx_block_fetch_pkg.sv
// rtl/tx_block_fetch_pkg.sv - shared types and defaults for the tx block fetch stage
package tx_block_fetch_pkg;

  localparam int MEM_DATA_WIDTH  = 8;
  localparam int MEM_ADDR_W      = 16;
  localparam int MEM_BLOCK_BYTES = 64;
  localparam int MEM_RAM_LAT     = 2;

  // Wide enough to hold the largest legal RAM latency (4)
  localparam int WAIT_CNT_W = 3;

  typedef logic [MEM_BLOCK_BYTES-1:0][MEM_DATA_WIDTH-1:0] block_t;
  typedef logic [MEM_ADDR_W-1:0] blk_addr_t;

  typedef struct packed {
    blk_addr_t next;
    logic      last;
  } link_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT    = 3'd2,
    DELIVER = 3'd3,
    ARMED   = 3'd4
  } fetch_state_t;

endpackage

// File: rtl/tx_free_slot.sv
// rtl/tx_free_slot.sv - single-entry valid/ready holding register for a freed block address
module tx_free_slot #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [ADDR_W-1:0] push_addr_i,
  output logic              valid_o,
  output logic [ADDR_W-1:0] addr_o,
  input  logic              ready_i
);

  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  // The fetch FSM never pushes while an entry is still pending, so push simply wins.
  always_comb begin
    valid_d = valid_q && !ready_i;
    addr_d  = addr_q;
    if (push_i) begin
      valid_d = 1'b1;
      addr_d  = push_addr_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
    end
  end

  assign valid_o = valid_q;
  assign addr_o  = addr_q;

endmodule

// File: rtl/tx_block_fetch.sv
// rtl/tx_block_fetch.sv - walks a frame's linked block list in block RAM, one block per request
module tx_block_fetch
  import tx_block_fetch_pkg::*;
#(
  parameter int DATA_WIDTH  = MEM_DATA_WIDTH,
  parameter int ADDR_W      = MEM_ADDR_W,
  parameter int BLOCK_BYTES = MEM_BLOCK_BYTES,
  parameter int RAM_LAT     = MEM_RAM_LAT
) (
  input  logic                              switch_clk,
  input  logic                              switch_rst,
  input  logic                              mem_start_i,
  input  logic [ADDR_W-1:0]                 mem_start_addr_i,
  input  logic                              mem_re_i,
  output logic [BLOCK_BYTES*DATA_WIDTH-1:0] frame_data_o,
  output logic                              frame_valid_o,
  output logic                              frame_end_o,
  output logic                              ram_re_o,
  output logic [ADDR_W-1:0]                 ram_addr_o,
  input  logic [BLOCK_BYTES*DATA_WIDTH-1:0] ram_data_i,
  input  logic [ADDR_W-1:0]                 link_next_i,
  input  logic                              link_last_i,
  output logic                              free_valid_o,
  output logic [ADDR_W-1:0]                 free_addr_o,
  input  logic                              free_ready_i,
  output logic                              busy_o,
  output logic                              err_o
);

  localparam int BW = BLOCK_BYTES * DATA_WIDTH;
  localparam logic [WAIT_CNT_W-1:0] LAT_INIT = WAIT_CNT_W'(RAM_LAT);
  localparam logic [WAIT_CNT_W-1:0] CNT_ONE  = WAIT_CNT_W'(1);

  fetch_state_t            state_q, state_d;
  logic [ADDR_W-1:0]       cur_addr_q, cur_addr_d;
  logic [ADDR_W-1:0]       next_ptr_q, next_ptr_d;
  logic                    last_q, last_d;
  logic [BW-1:0]           frame_data_q, frame_data_d;
  logic [WAIT_CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                    err_q, err_d;

  logic                    free_push;
  logic                    free_valid;
  logic                    free_stall;
  logic                    req_any;
  logic                    ram_re;
  logic                    frame_valid;

  assign req_any    = mem_re_i || mem_start_i;
  assign free_stall = free_valid && !free_ready_i;

  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    next_ptr_d   = next_ptr_q;
    last_d       = last_q;
    frame_data_d = frame_data_q;
    wait_cnt_d   = wait_cnt_q;
    err_d        = err_q;
    ram_re       = 1'b0;
    frame_valid  = 1'b0;
    free_push    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (mem_start_i) begin
          cur_addr_d = mem_start_addr_i;
          state_d    = ISSUE;
        end else if (mem_re_i) begin
          err_d = 1'b1;
        end
      end

      ISSUE: begin
        if (req_any) err_d = 1'b1;
        // Hold the read until the previous block's free has been accepted.
        if (!free_stall) begin
          ram_re     = 1'b1;
          wait_cnt_d = LAT_INIT;
          state_d    = WAIT;
        end
      end

      WAIT: begin
        if (req_any) err_d = 1'b1;
        if (wait_cnt_q == CNT_ONE) begin
          frame_data_d = ram_data_i;
          next_ptr_d   = link_next_i;
          last_d       = link_last_i;
          state_d      = DELIVER;
        end else begin
          wait_cnt_d = wait_cnt_q - CNT_ONE;
        end
      end

      DELIVER: begin
        if (req_any) err_d = 1'b1;
        frame_valid = 1'b1;
        free_push   = 1'b1;
        state_d     = last_q ? IDLE : ARMED;
      end

      ARMED: begin
        // A new frame start abandons the rest of the current chain.
        if (mem_start_i) begin
          cur_addr_d = mem_start_addr_i;
          state_d    = ISSUE;
        end else if (mem_re_i) begin
          cur_addr_d = next_ptr_q;
          state_d    = ISSUE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge switch_clk) begin
    if (switch_rst) begin
      state_q      <= IDLE;
      cur_addr_q   <= '0;
      next_ptr_q   <= '0;
      last_q       <= 1'b0;
      frame_data_q <= '0;
      wait_cnt_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      next_ptr_q   <= next_ptr_d;
      last_q       <= last_d;
      frame_data_q <= frame_data_d;
      wait_cnt_q   <= wait_cnt_d;
      err_q        <= err_d;
    end
  end

  tx_free_slot #(
    .ADDR_W (ADDR_W)
  ) u_free_slot (
    .clk         (switch_clk),
    .rst         (switch_rst),
    .push_i      (free_push),
    .push_addr_i (cur_addr_q),
    .valid_o     (free_valid),
    .addr_o      (free_addr_o),
    .ready_i     (free_ready_i)
  );

  assign free_valid_o  = free_valid;
  assign frame_data_o  = frame_data_q;
  assign frame_valid_o = frame_valid;
  assign frame_end_o   = frame_valid && last_q;
  assign ram_re_o      = ram_re;
  assign ram_addr_o    = cur_addr_q;
  assign busy_o        = (state_q != IDLE);
  assign err_o         = err_q;

endmodule
